icache_refill_arbiter: RTL
==========================

Name: icache_refill_arbiter

Overview:
- Shares one narrow 32-bit read-only memory port between NUM_REQ wide-line cache refill ports; typical clients are two instruction caches, or an instruction cache plus a prefetcher.
- On the requester side it presents the cache's wide refill handshake: valid held high, one-cycle ready pulse with the full line.
- On the memory side it issues NUM_BLOCKS sequential word reads and assembles them into one line.
- Requesters are selected round-robin.

Parameters:
- NUM_REQ, 2, number of refill requesters (2..8).
- NUM_BLOCKS, 4, 32-bit words per cache line (power of 2, at least 2).
- BLOCK_SIZE, 4, bytes per block; fixed at 4 and checked at elaboration.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester refill request, held until served or abandoned.
- req_addr  input  32*NUM_REQ  packed request addresses; requester r uses [32r +: 32].
- req_ready  output  NUM_REQ  one-hot, one-cycle pulse: line delivered to that requester.
- req_rdata  output  32*NUM_BLOCKS  assembled line, broadcast; valid only while req_ready is nonzero.
- mem_valid  output  1  memory read request.
- mem_ready  input  1  memory word valid; one-cycle pulse.
- mem_addr  output  32  word address of the current beat.
- mem_rdata  input  32  memory read data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low, effective mid-transfer):
  - mem_valid=0, mem_addr=0, req_ready=0, req_rdata=0, busy=0.
  - Round-robin pointer=0, state=IDLE, beat counter=0.
  - Any partial line is discarded.
- All outputs are registered.
- States are IDLE, FETCH, RESP, HOLD.
- IDLE:
  - If req_valid is nonzero, grant g = first valid requester at or after the pointer, cyclically.
  - Latch base = req_addr[g] with the low log2(NUM_BLOCKS)+2 bits cleared.
  - Set mem_addr=base, mem_valid=1, beat=0, pointer=(g+1) mod NUM_REQ, and go to FETCH.
- FETCH:
  - mem_valid stays high until mem_ready; the memory handshake is never withdrawn early.
  - On mem_ready, store mem_rdata into line[32*beat +: 32].
  - If this was not the last beat: beat+1, mem_addr+4.
  - On the last beat (beat==NUM_BLOCKS-1): drop mem_valid, drive req_rdata=line with the final word merged, set req_ready[g]=1, go to RESP.
- Abandon:
  - If req_valid[g] is sampled low in any FETCH cycle, set a sticky abort flag.
  - The outstanding beat still completes (wait for mem_ready); then drop mem_valid, give no ready pulse, and go to HOLD.
- RESP: req_ready clears the next cycle; go to HOLD.
- HOLD:
  - One cycle with no grant, because the cache's req_valid is still high in the cycle after ready.
  - Then go to IDLE.
- Line layout: word k comes from address base+4k and sits in bits [32k+31:32k], matching the cache's block_offset slicing.
- Latency: with mem_ready high on every mem_valid cycle, req_ready rises NUM_BLOCKS+1 cycles after req_valid is first sampled in IDLE. Throughput is one line per NUM_BLOCKS+3 cycles.
- Simultaneous requests: the round-robin winner is served; losers wait with valid held, and are served in pointer order, with no starvation.
- A new requester asserting valid during FETCH/RESP/HOLD waits; it never preempts a transfer in flight.
- mem_ready while mem_valid=0 is ignored.
- Address wrap: mem_addr increments within the line only; base alignment guarantees no carry beyond the line.

Decomposition:
- Shared package holds:
  - State encoding (IDLE/FETCH/RESP/HOLD).
  - WORD_BITS=32.
  - LINE_OFFSET_BITS=log2(NUM_BLOCKS)+2.
  - Beat-counter width localparam.
- Sub-module rr_arbiter(NUM_REQ): combinational round-robin pick from req_valid and pointer, giving one-hot grant and index. Pointer update stays in the parent.

Test Plan:
- Single requester:
  - Stimulus: req_valid[0]=1, addr 0x0000_1234, zero-wait memory returning word = address.
  - Response: mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C; req_ready=2'b01 exactly 5 cycles after request; req_rdata = {0x123C, 0x1238, 0x1234, 0x1230}.
- Simultaneous requests:
  - Stimulus: both requesters valid (addr0 0x100, addr1 0x200), each dropping valid one cycle after its ready pulse.
  - Response: requester 0 served first, then requester 1 (base 0x200); pointer=0 afterwards; a subsequent dual request grants 0 again.
- Wait states:
  - Stimulus: mem_ready delayed 3 cycles per beat.
  - Response: mem_valid and mem_addr stay stable while waiting; req_ready arrives at cycle 1+4*4.
- Abandon:
  - Stimulus: requester 0 drops valid during beat 1.
  - Response: beat 1 still completes, no req_ready pulse, HOLD, then IDLE; a pending requester 1 is granted next.
- Async reset mid-FETCH:
  - Stimulus: resetn low during beat 2.
  - Response: mem_valid=0 and busy=0 immediately, without waiting for a clock edge; after release, a new request restarts at beat 0.
- HOLD guard:
  - Stimulus: requester keeps valid high one cycle after ready, then drops it.
  - Response: no second grant and no memory traffic for that requester.

Source files
------------

// File: rtl/icache_refill_arbiter_pkg.sv
// icache_refill_arbiter_pkg: shared state encoding, widths and helpers for the refill arbiter
package icache_refill_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP, S_HOLD} state_t;
  localparam int WORD_BITS = 32;
  localparam int DEF_NUM_BLOCKS = 4;
  localparam int LINE_OFFSET_BITS = $clog2(DEF_NUM_BLOCKS) + 2;
  localparam int BEAT_BITS = $clog2(DEF_NUM_BLOCKS);
  function automatic int line_offset_bits(input int nb);
    return $clog2(nb) + 2;
  endfunction
  function automatic int beat_bits(input int nb);
    return $clog2(nb);
  endfunction
  function automatic int rr_idx(input int ptr, input int i, input int n);
    return (ptr + i) % n;
  endfunction
endpackage

// File: rtl/icache_refill_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first valid requester at or after the pointer
module rr_arbiter
  import icache_refill_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx
);
  logic w_found;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[rr_idx(int'(i_ptr), i, NUM_REQ)]) begin
        w_found = 1'b1;
        o_grant[rr_idx(int'(i_ptr), i, NUM_REQ)] = 1'b1;
        o_idx = PW'(rr_idx(int'(i_ptr), i, NUM_REQ));
      end
    end
  end
endmodule

// File: rtl/icache_refill_arbiter.sv
// icache_refill_arbiter: round-robin sharing of one 32-bit read port between wide-line refill clients
module icache_refill_arbiter
  import icache_refill_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [32*NUM_REQ-1:0]           req_addr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [32*NUM_BLOCKS-1:0]        req_rdata,
  output logic                            mem_valid,
  input  logic                            mem_ready,
  output logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_rdata,
  output logic                            busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = beat_bits(NUM_BLOCKS);
  localparam int LW = WORD_BITS * NUM_BLOCKS;
  localparam logic [31:0] BASE_MASK = ~((32'd1 << line_offset_bits(NUM_BLOCKS)) - 32'd1);

  if (BLOCK_SIZE != 4 || NUM_REQ < 2 || NUM_REQ > 8 || NUM_BLOCKS < 2 ||
      (NUM_BLOCKS & (NUM_BLOCKS - 1)) != 0) begin : g_bad_params
    $error("icache_refill_arbiter: unsupported parameter combination");
  end

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [BW-1:0]        r_beat;
  logic [LW-1:0]        r_line;
  logic                 r_abort;
  logic                 r_mem_valid;
  logic [31:0]          r_mem_addr;
  logic [NUM_REQ-1:0]   r_ready;
  logic [LW-1:0]        r_rdata;
  logic                 r_busy;
  logic [NUM_REQ-1:0]   w_grant;
  logic [PW-1:0]        w_gidx;
  logic                 w_abort;
  logic                 w_last;
  logic [LW-1:0]        w_line;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_idx(w_gidx)
  );

  // abandonment is sticky so a late re-assert cannot resurrect a withdrawn line
  assign w_abort = r_abort | ~|(req_valid & r_gnt);
  assign w_last = r_beat == BW'(NUM_BLOCKS - 1);
  always_comb begin
    w_line = r_line;
    w_line[WORD_BITS*r_beat +: WORD_BITS] = mem_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr <= '0;
      r_gnt <= '0;
      r_beat <= '0;
      r_line <= '0;
      r_abort <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr <= '0;
      r_ready <= '0;
      r_rdata <= '0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (|req_valid) begin
          r_gnt <= w_grant;
          r_ptr <= (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
          r_mem_addr <= req_addr[WORD_BITS*w_gidx +: WORD_BITS] & BASE_MASK;
          r_mem_valid <= 1'b1;
          r_beat <= '0;
          r_abort <= 1'b0;
          r_busy <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_abort <= w_abort;
          if (mem_ready) begin
            r_line <= w_line;
            if (w_abort || w_last) begin
              r_mem_valid <= 1'b0;
              r_state <= w_abort ? S_HOLD : S_RESP;
              if (!w_abort) begin
                r_rdata <= w_line;
                r_ready <= r_gnt;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
              r_mem_addr <= r_mem_addr + 32'd4;
            end
          end
        end
        S_RESP: begin
          r_ready <= '0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign req_rdata = r_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_addr = r_mem_addr;
  assign busy = r_busy;
endmodule
